// File: rtl/instr_sequencer_if.sv
// Handshake and program-load bundle for instr_sequencer.
// The slave modport is the sequencer; the master modport is whoever drives it.
interface instr_sequencer_if;
   logic        load_en;
   logic [3:0]  load_addr;
   logic [11:0] load_data;
   logic        start;
   logic        abort;
   logic        instr_ready;
   logic        instr_valid;
   logic [3:0]  opcode;
   logic [1:0]  rd;
   logic [1:0]  rs1;
   logic [1:0]  rs2;
   logic [3:0]  pc;
   logic        busy;
   logic        done;
   logic [7:0]  issue_count;

   modport master (
      output load_en, load_addr, load_data, start, abort, instr_ready,
      input  instr_valid, opcode, rd, rs1, rs2, pc, busy, done, issue_count
   );

   modport slave (
      input  load_en, load_addr, load_data, start, abort, instr_ready,
      output instr_valid, opcode, rd, rs1, rs2, pc, busy, done, issue_count
   );
endinterface

// File: rtl/instr_sequencer.sv
// Steps through a 16-word program memory, issuing one instruction per valid/ready handshake.
// Define SEQ_LOOP_EN to wrap from address 15 back to 0 instead of stopping.
module instr_sequencer (
   input logic              clk,
   input logic              rst_n,
   instr_sequencer_if.slave bus
);

`ifdef SEQ_LOOP_EN
   localparam bit LoopEn = 1'b1;
`else
   localparam bit LoopEn = 1'b0;
`endif

   localparam logic [3:0]  OpHalt   = 4'hE;
   localparam logic [11:0] HaltWord = 12'hE00;

   typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDone} state_e;

   state_e      state_q;
   logic [11:0] mem_q [16];
   logic [11:0] ir_q;
   logic [3:0]  pc_q;
   logic [7:0]  count_q;
   logic        valid_q;
   logic        busy_q;
   logic        done_q;
   logic        unused_rsvd;

   // Program memory only accepts writes while not executing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= HaltWord;
         end
      end else if (bus.load_en && (state_q == StIdle || state_q == StDone)) begin
         mem_q[bus.load_addr] <= bus.load_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         ir_q    <= '0;
         pc_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.abort) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q <= StFetch;
                  pc_q    <= '0;
                  count_q <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            StFetch: begin
               state_q <= StIssue;
               ir_q    <= mem_q[pc_q];
               valid_q <= (mem_q[pc_q][11:8] != OpHalt);
            end
            StIssue: begin
               // valid_q low here means the latched word is HALT.
               if (!valid_q) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else if (bus.instr_ready) begin
                  valid_q <= 1'b0;
                  if (count_q != 8'hFF) begin
                     count_q <= count_q + 8'd1;
                  end
                  if (pc_q == 4'hF && !LoopEn) begin
                     state_q <= StDone;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StFetch;
                     pc_q    <= pc_q + 4'd1;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign unused_rsvd     = ^ir_q[1:0];

   assign bus.instr_valid = valid_q;
   assign bus.opcode      = ir_q[11:8];
   assign bus.rd          = ir_q[7:6];
   assign bus.rs1         = ir_q[5:4];
   assign bus.rs2         = ir_q[3:2];
   assign bus.pc          = pc_q;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.issue_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: vector table, directed corner sequences and
// randomized programs checked against a program-walk model.
module tb_instr_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   instr_sequencer_if bus ();

   instr_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [11:0] word;
      logic        valid;
      logic [3:0]  op;
      logic [1:0]  rd;
      logic [1:0]  rs1;
      logic [1:0]  rs2;
      int          count;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [3:0] a, input logic [11:0] d);
      bus.load_en   = 1'b1;
      bus.load_addr = a;
      bus.load_data = d;
      tick();
      bus.load_en   = 1'b0;
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   initial begin
      bit          ok;
      logic [11:0] prog [16];
      logic [11:0] exp_word[$];
      logic [3:0]  exp_pc[$];
      logic [13:0] held;
      bit          stall_prev;
      bit          r;
      int          exp_len;

      bus.load_en     = 1'b0;
      bus.load_addr   = '0;
      bus.load_data   = '0;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.instr_ready = 1'b0;

      vecs[0] = '{12'h054, 1'b1, 4'h0, 2'd1, 2'd1, 2'd1, 1};
      vecs[1] = '{12'h7C8, 1'b1, 4'h7, 2'd3, 2'd0, 2'd2, 1};
      vecs[2] = '{12'hA2B, 1'b1, 4'hA, 2'd0, 2'd2, 2'd2, 1};
      vecs[3] = '{12'hF3C, 1'b1, 4'hF, 2'd0, 2'd3, 2'd3, 1};
      vecs[4] = '{12'hE3F, 1'b0, 4'hE, 2'd0, 2'd3, 2'd3, 0};
      vecs[5] = '{12'hE00, 1'b0, 4'hE, 2'd0, 2'd0, 2'd0, 0};

      #12 rst_n = 1'b1;
      tick();
      chk("rst_valid", bus.instr_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_pc", bus.pc, 0);
      chk("rst_count", bus.issue_count, 0);
      chk("rst_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2}, 0);

      // Empty memory: straight to HALT.
      bus.instr_ready = 1'b1;
      do_start();
      chk("nolo_fetch_busy", bus.busy, 1);
      chk("nolo_fetch_valid", bus.instr_valid, 0);
      tick();
      chk("nolo_issue_valid", bus.instr_valid, 0);
      tick();
      chk("nolo_done", bus.done, 1);
      chk("nolo_busy", bus.busy, 0);
      chk("nolo_count", bus.issue_count, 0);

      foreach (vecs[k]) begin
         load(4'd0, vecs[k].word);
         load(4'd1, 12'hE00);
         bus.instr_ready = 1'b1;
         do_start();
         chk($sformatf("vec%0d_fetch_busy", k), bus.busy, 1);
         tick();
         chk($sformatf("vec%0d_valid", k), bus.instr_valid, vecs[k].valid);
         chk($sformatf("vec%0d_fields", k), {bus.opcode, bus.rd, bus.rs1, bus.rs2},
             {vecs[k].op, vecs[k].rd, vecs[k].rs1, vecs[k].rs2});
         chk($sformatf("vec%0d_pc", k), bus.pc, 0);
         wait_done(10, ok);
         chk($sformatf("vec%0d_done", k), ok, 1);
         chk($sformatf("vec%0d_count", k), bus.issue_count, vecs[k].count);
      end

      // Load and start in the same cycle: fetch must see the new word.
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd0;
      bus.load_data = 12'h3A4;
      bus.start     = 1'b1;
      tick();
      bus.load_en   = 1'b0;
      bus.start     = 1'b0;
      tick();
      chk("ldst_valid", bus.instr_valid, 1);
      chk("ldst_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2}, {4'h3, 2'd2, 2'd2, 2'd1});
      wait_done(10, ok);
      chk("ldst_done", ok, 1);
      chk("ldst_count", bus.issue_count, 1);

      // Stall in ISSUE.
      load(4'd0, 12'h7C8);
      bus.instr_ready = 1'b0;
      do_start();
      tick();
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("stall_valid", bus.instr_valid, 1);
         chk("stall_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2}, {4'h7, 2'd3, 2'd0, 2'd2});
         chk("stall_pc", bus.pc, 0);
      end
      bus.instr_ready = 1'b1;
      tick();
      chk("stall_rel_valid", bus.instr_valid, 0);
      chk("stall_rel_pc", bus.pc, 1);
      chk("stall_rel_count", bus.issue_count, 1);
      wait_done(10, ok);
      chk("stall_done", ok, 1);

      // Abort with start in ISSUE at pc 2.
      load(4'd0, 12'h100);
      load(4'd1, 12'h100);
      load(4'd2, 12'h100);
      load(4'd3, 12'hE00);
      bus.instr_ready = 1'b1;
      do_start();
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.instr_valid && bus.pc == 4'd2) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("abort_reach_pc2", ok, 1);
      bus.instr_ready = 1'b0;
      bus.abort       = 1'b1;
      bus.start       = 1'b1;
      tick();
      bus.abort       = 1'b0;
      bus.start       = 1'b0;
      chk("abort_valid", bus.instr_valid, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done", bus.done, 0);
      chk("abort_pc", bus.pc, 2);
      chk("abort_count", bus.issue_count, 2);
      tick();
      chk("abort_stays_idle", bus.busy, 0);

      // Full program of non-HALT words, plus a write attempt while running.
      for (int a = 0; a < 16; a++) load(a[3:0], 12'h100);
      bus.instr_ready = 1'b1;
      do_start();
      bus.load_en   = 1'b1;
      bus.load_addr = 4'd5;
      bus.load_data = 12'hE00;
      tick();
      bus.load_en   = 1'b0;
`ifdef SEQ_LOOP_EN
      repeat (600) tick();
      chk("full_busy", bus.busy, 1);
      chk("full_count_sat", bus.issue_count, 255);
      bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
`else
      wait_done(100, ok);
      chk("full_done", ok, 1);
      chk("full_count", bus.issue_count, 16);
      chk("full_pc", bus.pc, 15);
`endif

      // Asynchronous reset mid-ISSUE.
      load(4'd0, 12'h054);
      bus.instr_ready = 1'b0;
      do_start();
      tick();
      chk("arst_pre_valid", bus.instr_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", bus.instr_valid, 0);
      chk("arst_busy", bus.busy, 0);
      chk("arst_pc_count", {bus.pc, bus.issue_count}, 0);
      chk("arst_fields", {bus.opcode, bus.rd, bus.rs1, bus.rs2}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.instr_ready = 1'b1;
      do_start();
      tick();
      chk("arst_halt_valid", bus.instr_valid, 0);
      tick();
      chk("arst_halt_done", bus.done, 1);
      chk("arst_halt_count", bus.issue_count, 0);

      // Random programs against a program-walk model.
      for (int it = 0; it < 15; it++) begin
         for (int i = 0; i < 16; i++) begin
            prog[i] = 12'($urandom);
            if ($urandom_range(0, 4) == 0) prog[i][11:8] = 4'hE;
         end
`ifdef SEQ_LOOP_EN
         prog[$urandom_range(0, 15)][11:8] = 4'hE;
`endif
         exp_word.delete();
         exp_pc.delete();
         for (int idx = 0; idx < 300; idx++) begin
`ifndef SEQ_LOOP_EN
            if (idx > 15) break;
`endif
            if (prog[idx % 16][11:8] == 4'hE) break;
            exp_word.push_back(prog[idx % 16]);
            exp_pc.push_back(4'(idx % 16));
         end
         exp_len = exp_word.size();
         for (int i = 0; i < 16; i++) load(i[3:0], prog[i]);
         do_start();
         stall_prev = 1'b0;
         held = '0;
         for (int c = 0; c < 300 && !bus.done; c++) begin
            if (stall_prev) begin
               chk("rnd_hold", {bus.instr_valid, bus.pc, bus.opcode, bus.rd, bus.rs1, bus.rs2},
                   {1'b1, held});
            end
            r = 1'($urandom);
            bus.instr_ready = r;
            if (bus.instr_valid && r) begin
               if (exp_word.size() == 0) begin
                  chk("rnd_extra_issue", 1, 0);
               end else begin
                  chk("rnd_issue", {bus.pc, bus.opcode, bus.rd, bus.rs1, bus.rs2},
                      {exp_pc.pop_front(), exp_word.pop_front()[11:2]});
               end
            end
            stall_prev = bus.instr_valid && !r;
            held = {bus.pc, bus.opcode, bus.rd, bus.rs1, bus.rs2};
            tick();
         end
         chk("rnd_done", bus.done, 1);
         chk("rnd_count", bus.issue_count, (exp_len > 255) ? 255 : exp_len);
         chk("rnd_left", exp_word.size(), 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all ports are listed below, clock and reset first.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 load_en  in  1  program-memory write strobe.
REQ-005 load_addr  in  4  program-memory write address.
REQ-006 load_data  in  12  instruction word: [11:8] opcode, [7:6] rd, [5:4] rs1, [3:2] rs2, [1:0] reserved.
REQ-007 start  in  1  begin execution at address 0.
REQ-008 abort  in  1  synchronous abort to IDLE.
REQ-009 instr_ready  in  1  downstream decoder accepts the instruction.
REQ-010 instr_valid  out  1  instruction outputs hold a valid instruction.
REQ-011 opcode  out  4  opcode to the control unit.
REQ-012 rd, rs1, rs2  out  2 each  register fields.
REQ-013 pc  out  4  address of the current instruction.
REQ-014 busy  out  1  high in FETCH or ISSUE.
REQ-015 done  out  1  high in DONE.
REQ-016 issue_count  out  8  handshakes since the last start; saturates at 255.

Function
REQ-017 SHALL contain a 16 x 12-bit register program memory, written at a clock edge when load_en=1 and state is IDLE or DONE; the write SHALL be ignored in any other state.
REQ-018 States SHALL be IDLE, FETCH, ISSUE and DONE.
REQ-019 IDLE or DONE with start=1 SHALL go to FETCH, set pc=0, clear issue_count and, from DONE, deassert done.
REQ-020 FETCH SHALL latch mem[pc] into the instruction register and go to ISSUE; FETCH lasts exactly 1 cycle.
REQ-021 In ISSUE, if the latched opcode is 4'hE (HALT), the sequencer SHALL go to DONE without asserting instr_valid.
REQ-022 In ISSUE with any other opcode, instr_valid SHALL be 1, and opcode, rd, rs1 and rs2 SHALL be held stable until instr_valid && instr_ready.
REQ-023 On a handshake, issue_count SHALL increment (saturating); if pc=15 the sequencer goes to DONE, otherwise pc increments and the sequencer goes to FETCH.
REQ-024 Opcode 4'hF (NOP) SHALL be issued like any other opcode.
REQ-025 Latency: start sampled at edge N gives FETCH in cycle N+1 and instr_valid in cycle N+2; back-to-back issue throughput is one instruction per 2 cycles.
REQ-026 abort=1 SHALL force IDLE at the next edge from any state, drop instr_valid and busy, and leave pc and issue_count unchanged.
REQ-027 abort SHALL take priority over start in the same cycle.
REQ-028 If load_en and start are asserted in the same IDLE cycle, both SHALL take effect, and the following FETCH SHALL see the newly written word.
REQ-029 instr_ready while instr_valid=0 SHALL be ignored.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, instr_valid=0, busy=0, done=0, pc=0, issue_count=0, and opcode/rd/rs1/rs2=0.
REQ-031 Reset SHALL fill every program-memory word with 12'hE00 (HALT).
REQ-032 Reset during ISSUE SHALL drop instr_valid asynchronously, with no handshake counted.

Configuration
REQ-033 With SEQ_LOOP_EN defined, a handshake at pc=15 SHALL wrap pc to 0 and go to FETCH (execution ends only on HALT or abort).
REQ-034 Without SEQ_LOOP_EN, REQ-023 behaviour applies: a handshake at pc=15 goes to DONE.

Verification
REQ-035 Reset then start, with no load: FETCH, then ISSUE sees HALT; done=1 at cycle N+3, instr_valid never asserts, issue_count=0.
REQ-036 Load mem[0]=12'h054 and mem[1]=12'hE00, start, instr_ready=1: opcode=0, rd=1, rs1=1, rs2=1 with instr_valid at N+2; then DONE; issue_count=1.
REQ-037 Hold instr_ready=0 for 5 cycles during ISSUE: instr_valid and the fields stay stable; pc does not advance until instr_ready=1.
REQ-038 Assert abort and start together during ISSUE: IDLE at the next cycle, instr_valid=0, pc unchanged.
REQ-039 All 16 words loaded with 12'h100 and instr_ready=1: 16 handshakes, then DONE, issue_count=16; with SEQ_LOOP_EN, pc wraps to 0 and issue_count saturates at 255.
REQ-040 Pulse rst_n low mid-ISSUE: outputs go to reset values immediately, and the next start with no reload ends at HALT.
